// File: rtl/id_fetch_queue_if.sv
// id_fetch_queue_if: fetch/decode handshake bundle for the instruction queue.
interface id_fetch_queue_if #(parameter int AW = 2);
  logic push;
  logic [31:0] push_pc;
  logic [31:0] push_inst;
  logic pop;
  logic flush;
  logic keep_one;
  logic full;
  logic empty;
  logic [AW:0] count;
  logic id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic drop_err;
  modport master (
    output push, push_pc, push_inst, pop, flush, keep_one,
    input full, empty, count, id_valid, id_inst, id_pc, drop_err
  );
  modport slave (
    input push, push_pc, push_inst, pop, flush, keep_one,
    output full, empty, count, id_valid, id_inst, id_pc, drop_err
  );
endinterface

// File: rtl/id_fetch_queue.sv
// id_fetch_queue: circular {pc, inst} queue between fetch and decode with flush/keep-one support.
module id_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input logic clk,
  input logic reset,
  id_fetch_queue_if.slave q
);
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, surv_ptr;
  logic [AW:0] cnt;
  logic full, empty, pop_ok, push_ok, has_surv, drop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign pop_ok = q.pop & !empty;
  assign push_ok = q.push & (!full | pop_ok);
  // the delay-slot survivor is the oldest entry not consumed this cycle
  assign surv_ptr = rd_ptr + AW'(pop_ok);
  assign has_surv = cnt > (AW+1)'(pop_ok);
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      drop <= 1'b0;
    end else if (q.flush) begin
      if (q.keep_one && has_surv) begin
        rd_ptr <= surv_ptr;
        wr_ptr <= surv_ptr + AW'(1);
        cnt <= (AW+1)'(1);
      end else begin
        rd_ptr <= wr_ptr;
        cnt <= '0;
      end
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (q.push && !push_ok) drop <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && !q.flush && push_ok) begin
      pc_mem[wr_ptr] <= q.push_pc;
      inst_mem[wr_ptr] <= q.push_inst;
    end
  end
  assign q.full = full;
  assign q.empty = empty;
  assign q.count = cnt;
  assign q.id_valid = !empty;
  assign q.id_inst = empty ? 32'h0 : inst_mem[rd_ptr];
  assign q.id_pc = empty ? 32'h0 : pc_mem[rd_ptr];
  assign q.drop_err = drop;
endmodule

// File: tb/tb_id_fetch_queue.sv
// tb_id_fetch_queue: table-driven directed check of id_fetch_queue plus multi-cycle corner sequences.
module tb_id_fetch_queue;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  id_fetch_queue_if #(.AW(2)) q();
  id_fetch_queue #(.DEPTH(4), .AW(2)) dut (.clk(clk), .reset(reset), .q(q));
  always #5 clk = ~clk;
  typedef struct {
    logic rst, push, pop, flush, keep;
    logic [31:0] inst;
    logic [2:0] cnt;
    logic drop;
    logic [31:0] head;
  } vec_t;
  vec_t vq[$];
  function automatic logic [31:0] pc_of(logic [31:0] inst);
    return 32'hbfc00000 + ((inst - 32'h1) << 2);
  endfunction
  function automatic void v(logic r, logic pu, logic [31:0] ins, logic po, logic fl, logic kp,
                            logic [2:0] c, logic d, logic [31:0] h);
    vec_t x;
    x.rst = r; x.push = pu; x.inst = ins; x.pop = po; x.flush = fl; x.keep = kp;
    x.cnt = c; x.drop = d; x.head = h;
    vq.push_back(x);
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic chk_state(string tag, logic [2:0] c, logic d, logic [31:0] h);
    chk({tag, " count"}, 32'(q.count), 32'(c));
    chk({tag, " full"}, 32'(q.full), 32'(c == 3'd4));
    chk({tag, " empty"}, 32'(q.empty), 32'(c == 3'd0));
    chk({tag, " id_valid"}, 32'(q.id_valid), 32'(c != 3'd0));
    chk({tag, " drop_err"}, 32'(q.drop_err), 32'(d));
    chk({tag, " id_inst"}, q.id_inst, c == 3'd0 ? 32'h0 : h);
    chk({tag, " id_pc"}, q.id_pc, c == 3'd0 ? 32'h0 : pc_of(h));
  endtask
  task automatic drive(logic r, logic pu, logic [31:0] ins, logic po, logic fl, logic kp);
    reset = r; q.push = pu; q.push_inst = ins; q.push_pc = pc_of(ins);
    q.pop = po; q.flush = fl; q.keep_one = kp;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // reset and fill; fifth push overflows
    v(0,1,32'h1,0,0,0,1,0,32'h1);
    v(0,1,32'h2,0,0,0,2,0,32'h1);
    v(0,1,32'h3,0,0,0,3,0,32'h1);
    v(0,1,32'h4,0,0,0,4,0,32'h1);
    v(0,1,32'h5,0,0,0,4,1,32'h1);
    v(1,1,32'h9,0,0,0,0,0,32'h0);
    // streaming at depth 2 across pointer wrap
    v(0,1,32'h100,0,0,0,1,0,32'h100);
    v(0,1,32'h101,0,0,0,2,0,32'h100);
    for (int k = 1; k <= 10; k++) v(0,1,32'h101 + 32'(k),1,0,0,2,0,32'h100 + 32'(k));
    // full with simultaneous push and pop
    v(1,0,32'h1,0,0,0,0,0,32'h0);
    v(0,1,32'h20,0,0,0,1,0,32'h20);
    v(0,1,32'h21,0,0,0,2,0,32'h20);
    v(0,1,32'h22,0,0,0,3,0,32'h20);
    v(0,1,32'h23,0,0,0,4,0,32'h20);
    v(0,1,32'hAA,1,0,0,4,0,32'h21);
    v(0,0,32'h1,1,0,0,3,0,32'h22);
    v(0,0,32'h1,1,0,0,2,0,32'h23);
    v(0,0,32'h1,1,0,0,1,0,32'hAA);
    v(0,0,32'h1,1,0,0,0,0,32'h0);
    // flush keep_one with pop: survivor is head+1
    v(1,0,32'h1,0,0,0,0,0,32'h0);
    v(0,1,32'h10,0,0,0,1,0,32'h10);
    v(0,1,32'h11,0,0,0,2,0,32'h10);
    v(0,1,32'h12,0,0,0,3,0,32'h10);
    v(0,1,32'h99,1,1,1,1,0,32'h11);
    v(0,0,32'h1,1,0,0,0,0,32'h0);
    // flush keep_one without pop: survivor is head, write pointer follows it
    v(1,0,32'h1,0,0,0,0,0,32'h0);
    v(0,1,32'h10,0,0,0,1,0,32'h10);
    v(0,1,32'h11,0,0,0,2,0,32'h10);
    v(0,1,32'h12,0,0,0,3,0,32'h10);
    v(0,1,32'h99,0,1,1,1,0,32'h10);
    v(0,1,32'h55,0,0,0,2,0,32'h10);
    v(0,0,32'h1,1,0,0,1,0,32'h55);
    v(0,0,32'h1,1,1,1,0,0,32'h0);
    v(0,1,32'h98,0,1,1,0,0,32'h0);
    // plain flush with push, then pop while empty
    v(0,1,32'h30,0,0,0,1,0,32'h30);
    v(0,1,32'h31,0,0,0,2,0,32'h30);
    v(0,1,32'h77,0,1,0,0,0,32'h0);
    v(0,0,32'h1,1,0,0,0,0,32'h0);
    v(0,1,32'h66,0,0,0,1,0,32'h66);
    // reset mid-stream clears sticky drop_err
    v(1,0,32'h1,0,0,0,0,0,32'h0);
    v(0,1,32'h40,0,0,0,1,0,32'h40);
    v(0,1,32'h41,0,0,0,2,0,32'h40);
    v(0,1,32'h42,0,0,0,3,0,32'h40);
    v(0,1,32'h43,0,0,0,4,0,32'h40);
    v(0,1,32'h44,0,0,0,4,1,32'h40);
    v(0,0,32'h1,1,0,0,3,1,32'h41);
    v(1,1,32'h45,0,0,0,0,0,32'h0);
    drive(1,0,32'h1,0,0,0);
    chk_state("reset", 3'd0, 1'b0, 32'h0);
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].push, vq[i].inst, vq[i].pop, vq[i].flush, vq[i].keep);
      chk_state($sformatf("vec%0d", i), vq[i].cnt, vq[i].drop, vq[i].head);
    end
    // inputs must not reach status or head outputs within a cycle
    drive(1,0,32'h1,0,0,0);
    for (int k = 0; k < 4; k++) drive(0,1,32'h50 + 32'(k),0,0,0);
    q.push = 1'b1; q.pop = 1'b1; q.flush = 1'b1; q.keep_one = 1'b0; q.push_inst = 32'h54;
    #2;
    chk("comb full", 32'(q.full), 32'h1);
    chk("comb count", 32'(q.count), 32'h4);
    chk("comb id_inst", q.id_inst, 32'h50);
    q.push = 1'b0; q.pop = 1'b0; q.flush = 1'b0;
    // reset held for several cycles with push active
    for (int k = 0; k < 3; k++) begin
      drive(1,1,32'h61,1,0,0);
      chk_state($sformatf("hold%0d", k), 3'd0, 1'b0, 32'h0);
    end
    drive(0,1,32'h60,0,0,0);
    chk_state("after_hold", 3'd1, 1'b0, 32'h60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
